// File: rtl/mash_dsm_pkg.sv
// Shared constants for the MASH 1-1-1 modulator family and its CIC3 decimator.
package mash_dsm_pkg;

    localparam int CIC_ORDER = 3;

    // Legal output span of a MASH 1-1-1: c1 + (1-z^-1)c2 + (1-z^-1)^2 c3
    localparam int MASH_MIN = -3;
    localparam int MASH_MAX = 4;

    function automatic int cic_out_width(input int in_width, input int dec_log2);
        return in_width + CIC_ORDER * dec_log2;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// Registered differentiator y = x - x_prev, advancing only on its enable strobe.
module cic_comb_stage #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic signed [WIDTH-1:0] i_x,
    output logic signed [WIDTH-1:0] o_y,
    output logic                    o_valid
);

    logic signed [WIDTH-1:0] r_dly;
    logic signed [WIDTH-1:0] r_y;
    logic                    r_valid;

    // Difference against the previous strobed input; the strobe moves one stage on
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dly   <= {WIDTH{1'b0}};
            r_y     <= {WIDTH{1'b0}};
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_en;
            if (i_en) begin
                r_y   <= i_x - r_dly;
                r_dly <= i_x;
            end
        end
    end

    assign o_y     = r_y;
    assign o_valid = r_valid;

endmodule

// File: rtl/mash_cic3_decim.sv
// Third-order CIC decimator (R = 2^DEC_LOG2) for the output of a MASH 1-1-1 modulator.
module mash_cic3_decim
    import mash_dsm_pkg::*;
#(
    parameter  int IN_WIDTH  = 4,
    parameter  int DEC_LOG2  = 4,
    localparam int OUT_WIDTH = cic_out_width(IN_WIDTH, DEC_LOG2)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  x_i,
    input  logic                        x_valid_i,
    input  logic                        clr_i,
    output logic signed [OUT_WIDTH-1:0] y_o,
    output logic                        y_valid_o,
    output logic                        range_err_o
);

    localparam logic signed [OUT_WIDTH-1:0] L_MIN = OUT_WIDTH'(MASH_MIN);
    localparam logic signed [OUT_WIDTH-1:0] L_MAX = OUT_WIDTH'(MASH_MAX);

    logic                        w_clear;
    logic                        w_last;
    logic                        w_oor;
    logic signed [OUT_WIDTH-1:0] w_x_ext;
    logic signed [OUT_WIDTH-1:0] w_int1;
    logic signed [OUT_WIDTH-1:0] w_int2;
    logic signed [OUT_WIDTH-1:0] w_int3;
    logic signed [OUT_WIDTH-1:0] w_c1;
    logic signed [OUT_WIDTH-1:0] w_c2;
    logic                        w_v1;
    logic                        w_v2;

    logic signed [OUT_WIDTH-1:0] r_int1;
    logic signed [OUT_WIDTH-1:0] r_int2;
    logic signed [OUT_WIDTH-1:0] r_int3;
    logic signed [OUT_WIDTH-1:0] r_decim;
    logic [DEC_LOG2-1:0]         r_dec_cnt;
    logic                        r_dec_stb;
    logic                        r_range_err;

    assign w_clear = rst | clr_i;
    assign w_last  = &r_dec_cnt;
    assign w_x_ext = {{(OUT_WIDTH - IN_WIDTH){x_i[IN_WIDTH-1]}}, x_i};
    assign w_oor   = (w_x_ext < L_MIN) || (w_x_ext > L_MAX);

    // Integrator chain settles within one cycle so the decimator sees int3 including this sample
    assign w_int1 = r_int1 + w_x_ext;
    assign w_int2 = r_int2 + w_int1;
    assign w_int3 = r_int3 + w_int2;

    // Integrators, decimation counter and range flag advance only on accepted samples
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_int1      <= {OUT_WIDTH{1'b0}};
            r_int2      <= {OUT_WIDTH{1'b0}};
            r_int3      <= {OUT_WIDTH{1'b0}};
            r_decim     <= {OUT_WIDTH{1'b0}};
            r_dec_cnt   <= {DEC_LOG2{1'b0}};
            r_dec_stb   <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            r_dec_stb <= x_valid_i & w_last;
            if (x_valid_i) begin
                r_int1    <= w_int1;
                r_int2    <= w_int2;
                r_int3    <= w_int3;
                r_dec_cnt <= r_dec_cnt + DEC_LOG2'(1);
                if (w_last) begin
                    r_decim <= w_int3;
                end
                if (w_oor) begin
                    r_range_err <= 1'b1;
                end
            end
        end
    end

    cic_comb_stage #(.WIDTH(OUT_WIDTH)) u_comb1 (
        .clk     (clk),
        .rst     (w_clear),
        .i_en    (r_dec_stb),
        .i_x     (r_decim),
        .o_y     (w_c1),
        .o_valid (w_v1)
    );

    cic_comb_stage #(.WIDTH(OUT_WIDTH)) u_comb2 (
        .clk     (clk),
        .rst     (w_clear),
        .i_en    (w_v1),
        .i_x     (w_c1),
        .o_y     (w_c2),
        .o_valid (w_v2)
    );

    // Last comb stage registers drive y_o / y_valid_o directly
    cic_comb_stage #(.WIDTH(OUT_WIDTH)) u_comb3 (
        .clk     (clk),
        .rst     (w_clear),
        .i_en    (w_v2),
        .i_x     (w_c2),
        .o_y     (y_o),
        .o_valid (y_valid_o)
    );

    assign range_err_o = r_range_err;

endmodule

// File: doc/mash_cic3_decim.md
MASH_CIC3_DECIM -- requirements
Module: mash_cic3_decim

Interface
REQ-001 Parameter IN_WIDTH, default 4: width of the signed MASH 1-1-1 output sample consumed.
REQ-002 Parameter DEC_LOG2, default 4: decimation ratio R = 2^DEC_LOG2; legal range 1..8.
REQ-003 Derived width OUT_WIDTH = IN_WIDTH + 3*DEC_LOG2 (16 at defaults); not overridable.
REQ-004 Port clk, input, 1: single clock; every register is on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port x_i, input, IN_WIDTH: signed two's-complement modulator output sample; nominal range -3..+4.
REQ-007 Port x_valid_i, input, 1: x_i is accepted on a rising edge where this is high.
REQ-008 Port clr_i, input, 1: synchronous datapath clear, same effect as rst, no priority over rst.
REQ-009 Port y_o, output, OUT_WIDTH: signed decimated CIC3 output.
REQ-010 Port y_valid_o, output, 1: one-cycle strobe marking a new y_o.
REQ-011 Port range_err_o, output, 1: sticky flag for an accepted x_i outside -3..+4.

Function
REQ-012 Filter: third-order CIC, differential delay 1.
- Transfer function: ((1 - z^-R)/(1 - z^-1))^3.
- DC gain: R^3 = 2^(3*DEC_LOG2).
REQ-013 Integrators int1..int3, OUT_WIDTH each:
- Update only on accepted samples.
- Chained combinationally within one cycle: int1' = int1 + sext(x_i), int2' = int2 + int1', int3' = int3 + int2'.
REQ-014 Integrator and comb arithmetic wraps modulo 2^OUT_WIDTH; no saturation anywhere.
REQ-015 x_valid_i low: integrators, decimation counter and range check hold their values.
REQ-016 Decimation counter:
- Counts accepted samples 0..R-1, wrapping R-1 -> 0.
- On the edge that accepts the sample with count R-1, int3' is captured into the decimation register and an internal strobe is raised.
REQ-017 Comb pipeline: three registered comb stages, c_k = in_k - d_k, where d_k holds the previous decimated input of stage k.
- Each stage advances one edge after the previous stage, only when the strobe propagates.
REQ-018 Latency: y_o and y_valid_o update on edge 4, counting the edge that accepted the R-th sample as edge 1.
- y_valid_o is high for exactly one cycle.
REQ-019 y_o holds its last value between strobes.
REQ-020 Back-to-back decimation strobes occur no closer than R accepted samples apart; the pipeline never stalls and has no ready signal.
REQ-021 range_err_o sets on any accepted x_i < -3 or > +4.
- The sample is still filtered.
- The flag clears only on rst or clr_i.
REQ-022 clr_i or rst asserted in the same cycle as an accepted sample: the sample is discarded and the clear wins.
- Any in-flight comb strobe is cancelled; no y_valid_o is issued for it.

Reset
REQ-023 On rst, the following clear to 0 at the next edge:
- all integrators, comb delay registers and the decimation counter;
- y_o, y_valid_o and range_err_o.
REQ-024 The first decimated output after reset is counted from the first accepted sample after rst deasserts.

Structure
REQ-025 Shared package mash_dsm_pkg holds:
- the CIC order constant (3);
- the legal MASH 1-1-1 output range constants (-3, +4);
- a width function returning IN_WIDTH + 3*DEC_LOG2.
REQ-026 One sub-module, cic_comb_stage, is instantiated three times.
- Contents: registered differentiator with enable and clear, parameterised width.

Verification
REQ-027 Defaults; x_i=+1 held, x_valid_i=1 continuously -> y_o sequence 816, 3536, 4096, 4096, ...; y_valid_o every 16 cycles.
REQ-028 Defaults; x_i=-3 held -> settles from the third output onward to y_o = -12288; x_i=+4 held -> y_o = 16384; no range_err_o.
REQ-029 Defaults; x_i=+1 with x_valid_i toggling 1/0 -> the same 816, 3536, 4096 values; y_valid_o every 32 cycles.
REQ-030 Feed the output of the dithered MASH 1-1-1 (WIDTH=4, input 4'b1000) into this block, 10000 cycles -> the mean of settled y_o is 2048 +/- 64; range_err_o stays 0.
REQ-031 Inject one accepted x_i = -5 -> range_err_o rises on that edge and stays high; clr_i pulse -> it returns to 0 and the next outputs repeat 816, 3536, 4096.
REQ-032 Assert rst two cycles before a pending decimation strobe reaches y_o -> no y_valid_o; y_o = 0; restarting with +1 gives 816 first.
